// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debounce block.
//
// Contents:
//   state_e                  - FSM state encoding (RELEASED, WAIT_PRESS,
//                              PRESSED, WAIT_RELEASE in a 2-bit code)
//   DEFAULT_DEBOUNCE_CYCLES  - debounce length for the board clock
//   DEFAULT_LONG_CYCLES      - long-press threshold for the board clock
//   DEFAULT_CNT_W            - counter width that covers the defaults
//   paramsLegal()            - elaboration-time parameter sanity check
package button_debounce_pkg;

  // The encoding values are fixed so that state dumps and any downstream
  // debug logic can rely on them.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_LONG_CYCLES     = 1000;
  localparam int DEFAULT_CNT_W           = 16;

  // The debounce needs at least two samples to mean anything, the long
  // threshold must lie beyond the debounce window, and the counters must
  // be wide enough to hold the long threshold without wrapping.
  function automatic bit paramsLegal(int debCycles, int longCycles, int cntW);
    bit ok;
    ok = (debCycles >= 2) && (longCycles > debCycles) &&
         (cntW >= 1) && (cntW <= 62);
    if (ok) begin
      ok = (longint'(1) << cntW) > longint'(longCycles);
    end
    return ok;
  endfunction

endpackage

// File: rtl/button_debounce_sat.sv
// Saturating up-counter with a limit-reached pulse.
//
// Ports:
//   clk       in   system clock, posedge
//   rst_n     in   asynchronous active-low reset
//   clear_i   in   synchronous clear, wins over enable
//   enable_i  in   count one step this cycle
//   value_o   out  current count, never exceeds LIMIT
//   hit_o     out  high in the cycle whose edge takes the count from
//                  LIMIT-1 to LIMIT, so the caller can register it
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] value_o,
  output logic             hit_o
);

  localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] value_q;

  // Count while enabled and stop at the limit; the count is held there
  // until the next clear so the limit crossing can only happen once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (clear_i) begin
      value_q <= '0;
    end else if (enable_i && (value_q != LIM)) begin
      value_q <= value_q + WIDTH'(1);
    end
  end

  // Announce the crossing one edge early so the owner can register its
  // own pulse on the very edge the count reaches the limit.
  assign hit_o   = enable_i && !clear_i && (value_q == LIM_M1);
  assign value_o = value_q;

endmodule

// File: rtl/button_debounce.sv
// Debounce and event extraction for a synchronised button level.
//
// Ports:
//   clk            in   system clock, posedge
//   rst_n          in   asynchronous active-low reset
//   sync_in        in   synchronised raw button level, 1 = pressed
//   btn_level      out  debounced button level
//   press_pulse    out  one-cycle pulse when a press is accepted
//   release_pulse  out  one-cycle pulse when a release is accepted
//   long_press     out  one-cycle pulse LONG_CYCLES edges after the press
//                       was accepted, at most once per press
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);

  // Refuse to elaborate with parameters that would make the counters wrap
  // or the debounce window meaningless.
  if (!paramsLegal(DEBOUNCE_CYCLES, LONG_CYCLES, CNT_W)) begin : gen_bad_params
    $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES/CNT_W");
  end

  state_e           state_q;
  logic [CNT_W-1:0] debCnt_q;
  logic             btnLevel_q;
  logic             pressPulse_q;
  logic             releasePulse_q;
  logic             longPress_q;

  logic             debDone;
  logic             pressAccept;
  logic             releaseAccept;
  logic [CNT_W-1:0] holdCnt;
  logic             holdHit;

  // The debounce counter already holds the number of matching samples
  // seen before this edge, so reaching DEB_LAST while the input still
  // matches means this edge is the final required sample.
  assign debDone       = (debCnt_q == DEB_LAST);
  assign pressAccept   = (state_q == ST_WAIT_PRESS)   &&  sync_in && debDone;
  assign releaseAccept = (state_q == ST_WAIT_RELEASE) && !sync_in && debDone;

  // Hold time runs for as long as the debounced level is high, through
  // release bounce too, and restarts on every accepted press.
  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (LONG_CYCLES)
  ) uHoldCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (pressAccept),
    .enable_i (btnLevel_q),
    .value_o  (holdCnt),
    .hit_o    (holdHit)
  );

  // Main debounce FSM with registered outputs. Pulses default low each
  // edge so they are exactly one cycle wide. A release accepted on the
  // same edge as the long threshold suppresses the long pulse; since the
  // hold counter saturates on that edge, no long pulse follows later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RELEASED;
      debCnt_q       <= '0;
      btnLevel_q     <= 1'b0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      longPress_q    <= 1'b0;
    end else begin
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      longPress_q    <= holdHit && !releaseAccept;

      case (state_q)
        ST_RELEASED: begin
          if (sync_in) begin
            state_q  <= ST_WAIT_PRESS;
            debCnt_q <= CNT_W'(1);
          end else begin
            debCnt_q <= '0;
          end
        end

        ST_WAIT_PRESS: begin
          if (!sync_in) begin
            state_q  <= ST_RELEASED;
            debCnt_q <= '0;
          end else if (debDone) begin
            state_q      <= ST_PRESSED;
            btnLevel_q   <= 1'b1;
            pressPulse_q <= 1'b1;
            debCnt_q     <= '0;
          end else begin
            debCnt_q <= debCnt_q + CNT_W'(1);
          end
        end

        ST_PRESSED: begin
          if (!sync_in) begin
            state_q  <= ST_WAIT_RELEASE;
            debCnt_q <= CNT_W'(1);
          end else begin
            debCnt_q <= '0;
          end
        end

        ST_WAIT_RELEASE: begin
          if (sync_in) begin
            state_q  <= ST_PRESSED;
            debCnt_q <= '0;
          end else if (debDone) begin
            state_q        <= ST_RELEASED;
            btnLevel_q     <= 1'b0;
            releasePulse_q <= 1'b1;
            debCnt_q       <= '0;
          end else begin
            debCnt_q <= debCnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q  <= ST_RELEASED;
          debCnt_q <= '0;
        end
      endcase
    end
  end

  // Structural invariants: the hold count is saturating and the two edge
  // pulses come from mutually exclusive FSM transitions.
  assert property (@(posedge clk) disable iff (!rst_n) holdCnt <= LONG_LIM);
  assert property (@(posedge clk) disable iff (!rst_n) !(pressPulse_q && releasePulse_q));

  assign btn_level     = btnLevel_q;
  assign press_pulse   = pressPulse_q;
  assign release_pulse = releasePulse_q;
  assign long_press    = longPress_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with a short debounce window
// and long-press threshold so every corner fits in a few thousand cycles.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic syncIn;
  logic btnLevel;
  logic pressPulse;
  logic releasePulse;
  logic longPress;

  int checks = 0;
  int errors = 0;

  // Reference model state: accepted level, length of the current run of
  // samples that disagree with it, and edges since the last press.
  bit mLevel;
  int mRun;
  int mAge;
  bit mPress;
  bit mRelease;
  bit mLong;

  typedef struct {
    bit       s;
    bit [3:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Free-running clock
  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .CNT_W           (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_in       (syncIn),
    .btn_level     (btnLevel),
    .press_pulse   (pressPulse),
    .release_pulse (releasePulse),
    .long_press    (longPress)
  );

  // Model reset mirrors the observable reset behaviour only
  function void modelReset();
    mLevel   = 1'b0;
    mRun     = 0;
    mAge     = 0;
    mPress   = 1'b0;
    mRelease = 1'b0;
    mLong    = 1'b0;
  endfunction

  // A level change is accepted once DEB consecutive samples disagree with
  // the accepted level; long fires LONG edges into a press unless the
  // release lands on that same edge.
  function void modelStep(bit s);
    bit prevLevel;
    bit releasedNow;
    prevLevel   = mLevel;
    releasedNow = 1'b0;
    mPress      = 1'b0;
    mRelease    = 1'b0;
    mLong       = 1'b0;
    if (s != mLevel) begin
      mRun++;
      if (mRun == DEB) begin
        mLevel = s;
        mRun   = 0;
        if (s) begin
          mPress = 1'b1;
        end else begin
          mRelease    = 1'b1;
          releasedNow = 1'b1;
        end
      end
    end else begin
      mRun = 0;
    end
    if (prevLevel) begin
      mAge++;
      if ((mAge == LONG) && !releasedNow) begin
        mLong = 1'b1;
      end
    end
    if (mPress) begin
      mAge = 0;
    end
  endfunction

  // Drive one sample between edges, then advance the model past the edge
  task applyStimulus(input bit s);
    @(negedge clk);
    syncIn = s;
    @(posedge clk);
    #1;
    modelStep(s);
  endtask

  // Compare {level, press, release, long} against the required pattern
  task checkOutput(input string name, input bit [3:0] exp);
    bit [3:0] got;
    got = {btnLevel, pressPulse, releasePulse, longPress};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: level/press/release/long got %b required %b at %0t",
               name, got, exp, $time);
    end
  endtask

  task checkModel(input string name);
    checkOutput(name, {mLevel, mPress, mRelease, mLong});
  endtask

  task checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int pressIdx;
    int longIdx;
    int longCount;
    int segLen;
    bit segLvl;
    bit s;

    // Clean press with leading bounce, then release glitch and release.
    // exp = {level, press, release, long}
    vecs[0]  = '{1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0000};
    vecs[4]  = '{1'b1, 4'b0000};
    vecs[5]  = '{1'b1, 4'b0000};
    vecs[6]  = '{1'b1, 4'b0000};
    vecs[7]  = '{1'b1, 4'b1100};
    vecs[8]  = '{1'b1, 4'b1000};
    vecs[9]  = '{1'b0, 4'b1000};
    vecs[10] = '{1'b0, 4'b1000};
    vecs[11] = '{1'b0, 4'b1000};
    vecs[12] = '{1'b1, 4'b1000};
    vecs[13] = '{1'b0, 4'b1000};
    vecs[14] = '{1'b0, 4'b1000};
    vecs[15] = '{1'b0, 4'b1000};
    vecs[16] = '{1'b0, 4'b0010};
    vecs[17] = '{1'b0, 4'b0000};

    rst_n  = 1'b0;
    syncIn = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 4'b0000);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int k = 0; k < 18; k++) begin
      applyStimulus(vecs[k].s);
      checkOutput($sformatf("vec%0d", k), vecs[k].exp);
    end

    $display("[TB] long press");
    pressIdx  = -1;
    longIdx   = -1;
    longCount = 0;
    for (int i = 0; i < DEB + 40; i++) begin
      applyStimulus(1'b1);
      checkModel("long_seq");
      if (pressPulse) pressIdx = i;
      if (longPress) begin
        longCount++;
        longIdx = i;
      end
    end
    checkValue("long_count", longCount, 1);
    checkValue("long_press_idx", pressIdx, DEB - 1);
    checkValue("long_offset", longIdx - pressIdx, LONG);
    for (int i = 0; i < DEB + 2; i++) begin
      applyStimulus(1'b0);
      checkModel("long_release");
    end

    $display("[TB] release/long collision");
    longCount = 0;
    for (int i = 0; i < DEB + 16 + DEB; i++) begin
      s = (i < DEB + 16) ? 1'b1 : 1'b0;
      applyStimulus(s);
      checkModel("collision_seq");
      if (longPress) longCount++;
      if (i == DEB + 16 + DEB - 1) begin
        checkOutput("collision_edge", 4'b0010);
      end
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0);
      checkModel("collision_after");
      if (longPress) longCount++;
    end
    checkValue("collision_long_count", longCount, 0);

    $display("[TB] async reset mid-press");
    for (int i = 0; i < DEB + 4; i++) begin
      applyStimulus(1'b1);
      checkModel("pre_reset");
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000);
    @(negedge clk);
    rst_n  = 1'b1;
    syncIn = 1'b1;
    modelReset();
    pressIdx = -1;
    for (int i = 0; i < DEB + 2; i++) begin
      if (i > 0) @(negedge clk);
      syncIn = 1'b1;
      @(posedge clk);
      #1;
      modelStep(1'b1);
      checkModel("post_reset");
      if (pressPulse) pressIdx = i;
    end
    checkValue("post_reset_press_idx", pressIdx, DEB - 1);

    $display("[TB] randomized segments");
    for (int n = 0; n < 150; n++) begin
      segLvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        segLen = int'($urandom_range(1, DEB - 1));
      end else begin
        segLen = int'($urandom_range(1, 35));
      end
      for (int j = 0; j < segLen; j++) begin
        applyStimulus(segLvl);
        checkModel("random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
